// File: rtl/fp_issue_scoreboard_if.sv
// Decode-to-scoreboard issue bus plus the scoreboard's stall, writeback and status returns.
// Decode side uses the master modport; the scoreboard uses the slave modport.
interface fp_issue_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int LW    = 4
);
  logic             issue_valid_i;
  logic [AW-1:0]    issue_rs1_i;
  logic [AW-1:0]    issue_rs2_i;
  logic             issue_use_rs1_i;
  logic             issue_use_rs2_i;
  logic             issue_we_i;
  logic [AW-1:0]    issue_rd_i;
  logic [LW-1:0]    issue_lat_i;
  logic             flush_i;
  logic             stall_o;
  logic             issue_fire_o;
  logic             wb_valid_o;
  logic [AW-1:0]    wb_rd_o;
  logic [NREGS-1:0] busy_o;
  logic [LW-1:0]    inflight_o;

  modport master (
    output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_use_rs1_i, issue_use_rs2_i,
           issue_we_i, issue_rd_i, issue_lat_i, flush_i,
    input  stall_o, issue_fire_o, wb_valid_o, wb_rd_o, busy_o, inflight_o
  );

  modport slave (
    input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_use_rs1_i, issue_use_rs2_i,
           issue_we_i, issue_rd_i, issue_lat_i, flush_i,
    output stall_o, issue_fire_o, wb_valid_o, wb_rd_o, busy_o, inflight_o
  );
endinterface

// File: rtl/fp_issue_scoreboard.sv
// Variable-latency issue scoreboard: a result shift register owns the single writeback
// slot, per-register busy bits block RAW/WAW hazards, and a taken branch kills the last issue.
module fp_issue_scoreboard #(
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int LAT_MAX = 8,
  parameter int LW      = 4
) (
  input  logic                clk,
  input  logic                reset,
  fp_issue_scoreboard_if.slave bus
);

  logic [LAT_MAX:0] r_slot_v;
  logic [AW-1:0]    r_slot_rd [LAT_MAX+1];
  logic [NREGS-1:0] r_busy;
  logic             r_lv;
  logic [AW-1:0]    r_lrd;
  logic [LW-1:0]    r_llat;
  logic [LW-1:0]    r_inflight;

  logic             w_lat_ok;
  logic             w_raw;
  logic             w_waw;
  logic             w_wbc;
  logic             w_stall;
  logic             w_fire;
  logic             w_alloc;
  logic             w_kill;
  logic             w_wb_valid;
  logic [LAT_MAX:0] w_cur_v;
  logic [LAT_MAX:0] w_slot_v_next;
  logic [AW-1:0]    w_slot_rd_next [LAT_MAX+1];
  logic [NREGS-1:0] w_busy_next;
  logic [LW-1:0]    w_inflight_next;

  always_comb begin
    w_lat_ok = (bus.issue_lat_i != '0) && (bus.issue_lat_i <= LW'(LAT_MAX));
    w_raw = (bus.issue_use_rs1_i && (bus.issue_rs1_i != '0) && r_busy[bus.issue_rs1_i]) ||
            (bus.issue_use_rs2_i && (bus.issue_rs2_i != '0) && r_busy[bus.issue_rs2_i]);
    w_waw = bus.issue_we_i && (bus.issue_rd_i != '0) && r_busy[bus.issue_rd_i];
    w_wbc = 1'b0;
    for (int k = 1; k <= LAT_MAX; k++) begin
      if (bus.issue_we_i && (LW'(k) == bus.issue_lat_i) && r_slot_v[k]) w_wbc = 1'b1;
    end
    // Reset also masks the combinational handshake so nothing is accepted while held.
    w_stall = reset && bus.issue_valid_i && !bus.flush_i && (w_raw || w_waw || w_wbc);
    w_fire  = reset && bus.issue_valid_i && !bus.flush_i && !w_stall;
    w_alloc = w_fire && bus.issue_we_i && (bus.issue_rd_i != '0) && w_lat_ok;
    w_kill  = bus.flush_i && r_lv;
    w_wb_valid = r_slot_v[0] && !(w_kill && (r_llat == LW'(1)));
  end

  always_comb begin
    w_cur_v = r_slot_v;
    for (int k = 0; k < LAT_MAX; k++) begin
      if (w_kill && (LW'(k + 1) == r_llat)) w_cur_v[k] = 1'b0;
    end
    w_slot_v_next = {1'b0, w_cur_v[LAT_MAX:1]};
    for (int k = 0; k < LAT_MAX; k++) w_slot_rd_next[k] = r_slot_rd[k+1];
    w_slot_rd_next[LAT_MAX] = '0;
    // The new entry lands one slot below L because it is written after this edge's shift.
    for (int k = 0; k < LAT_MAX; k++) begin
      if (w_alloc && (LW'(k + 1) == bus.issue_lat_i)) begin
        w_slot_v_next[k]  = 1'b1;
        w_slot_rd_next[k] = bus.issue_rd_i;
      end
    end
    w_inflight_next = '0;
    for (int k = 0; k <= LAT_MAX; k++) begin
      w_inflight_next = w_inflight_next + {{(LW-1){1'b0}}, w_slot_v_next[k]};
    end
  end

  always_comb begin
    w_busy_next = r_busy;
    if (w_wb_valid) w_busy_next[r_slot_rd[0]] = 1'b0;
    if (w_kill)     w_busy_next[r_lrd] = 1'b0;
    if (w_alloc)    w_busy_next[bus.issue_rd_i] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot_v   <= '0;
      r_slot_rd  <= '{default: '0};
      r_busy     <= '0;
      r_lv       <= 1'b0;
      r_lrd      <= '0;
      r_llat     <= '0;
      r_inflight <= '0;
    end else begin
      r_slot_v   <= w_slot_v_next;
      r_slot_rd  <= w_slot_rd_next;
      r_busy     <= w_busy_next;
      // Only an allocating issue has anything for a following flush to undo.
      r_lv       <= w_alloc;
      r_lrd      <= w_alloc ? bus.issue_rd_i : '0;
      r_llat     <= w_alloc ? bus.issue_lat_i : '0;
      r_inflight <= w_inflight_next;
    end
  end

  assign bus.stall_o      = w_stall;
  assign bus.issue_fire_o = w_fire;
  assign bus.wb_valid_o   = w_wb_valid;
  assign bus.wb_rd_o      = r_slot_rd[0];
  assign bus.busy_o       = r_busy;
  assign bus.inflight_o   = r_inflight;

endmodule

// File: tb/tb_fp_issue_scoreboard.sv
// Bench for fp_issue_scoreboard: directed hazard/flush/reset scenarios and a random run,
// all checked each cycle against a queue of pending writebacks keyed by writeback cycle.
module tb_fp_issue_scoreboard;
  localparam int NREGS = 32, AW = 5, LAT_MAX = 8, LW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fp_issue_scoreboard_if #(.NREGS(NREGS), .AW(AW), .LW(LW)) ifc ();

  fp_issue_scoreboard #(.NREGS(NREGS), .AW(AW), .LAT_MAX(LAT_MAX), .LW(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct { int rd; int wb; } ent_t;
  ent_t pend[$];
  int   cyc = 0;
  bit   lv = 0;
  int   lrd = 0;
  int   checks = 0;
  int   errors = 0;

  logic             obs_fire, obs_stall, obs_wb;
  logic [AW-1:0]    obs_wbrd;
  logic [NREGS-1:0] obs_busy;
  logic [LW-1:0]    obs_infl;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && ifc.issue_valid_i)
      assert (ifc.issue_lat_i >= 1 && ifc.issue_lat_i <= LAT_MAX) else begin
        errors++;
        $error("FAIL lat_legal observed=%0d expected=1..%0d", ifc.issue_lat_i, LAT_MAX);
      end
  end

  task automatic drive(bit v, int rs1, bit u1, int rs2, bit u2, bit we, int rd, int lat, bit fl);
    ifc.issue_valid_i   = v;
    ifc.issue_rs1_i     = AW'(rs1);
    ifc.issue_use_rs1_i = u1;
    ifc.issue_rs2_i     = AW'(rs2);
    ifc.issue_use_rs2_i = u2;
    ifc.issue_we_i      = we;
    ifc.issue_rd_i      = AW'(rd);
    ifc.issue_lat_i     = LW'(lat);
    ifc.flush_i         = fl;
  endtask

  // One clock cycle: drive, compare every output with the pending-queue model, advance.
  task automatic step(bit v, int rs1, bit u1, int rs2, bit u2, bit we, int rd, int lat, bit fl);
    bit kill, raw, waw, wbc, st, fi, wbv;
    int wbrd;
    logic [NREGS-1:0] bz;
    drive(v, rs1, u1, rs2, u2, we, rd, lat, fl);
    @(negedge clk);
    bz = '0;
    foreach (pend[i]) bz[pend[i].rd] = 1'b1;
    kill = fl && lv;
    wbv = 0;
    wbrd = 0;
    foreach (pend[i])
      if (pend[i].wb == cyc && !(kill && pend[i].rd == lrd)) begin
        wbv = 1;
        wbrd = pend[i].rd;
      end
    raw = (u1 && rs1 != 0 && bz[rs1]) || (u2 && rs2 != 0 && bz[rs2]);
    waw = we && rd != 0 && bz[rd];
    wbc = 0;
    if (we) foreach (pend[i]) if (pend[i].wb == cyc + lat) wbc = 1;
    st = v && !fl && (raw || waw || wbc);
    fi = v && !fl && !st;
    obs_fire  = ifc.issue_fire_o;
    obs_stall = ifc.stall_o;
    obs_wb    = ifc.wb_valid_o;
    obs_wbrd  = ifc.wb_rd_o;
    obs_busy  = ifc.busy_o;
    obs_infl  = ifc.inflight_o;
    check("stall", obs_stall, st);
    check("fire", obs_fire, fi);
    check("wb_valid", obs_wb, wbv);
    if (wbv) check("wb_rd", obs_wbrd, wbrd);
    check("busy", obs_busy, bz);
    check("inflight", obs_infl, pend.size());
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].wb == cyc || (kill && pend[i].rd == lrd)) pend.delete(i);
    if (fi && we && rd != 0) begin
      pend.push_back('{rd, cyc + lat});
      lv = 1;
      lrd = rd;
    end else begin
      lv = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_stall"}, ifc.stall_o, 0);
    check({tag, "_fire"}, ifc.issue_fire_o, 0);
    check({tag, "_wb_valid"}, ifc.wb_valid_o, 0);
    check({tag, "_wb_rd"}, ifc.wb_rd_o, 0);
    check({tag, "_busy"}, ifc.busy_o, 0);
    check({tag, "_inflight"}, ifc.inflight_o, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #3;
    check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Integer op rd=5, L=1
    step(1, 0, 0, 0, 0, 1, 5, 1, 0);   check("t1_fire_c0", obs_fire, 1);
    idle(1);  check("t1_wb_c1", obs_wb, 1); check("t1_wbrd_c1", obs_wbrd, 5);
              check("t1_busy5_c1", obs_busy[5], 1);
    idle(1);  check("t1_busy5_c2", obs_busy[5], 0); check("t1_infl_c2", obs_infl, 0);

    // FP op rd=3, L=4, dependent rs1=3 held in D
    step(1, 0, 0, 0, 0, 1, 3, 4, 0);
    for (int c = 1; c <= 4; c++) begin
      step(1, 3, 1, 0, 0, 1, 10, 1, 0);
      check("t2_stall", obs_stall, 1);
    end
    check("t2_wb_c4", obs_wb, 1); check("t2_wbrd_c4", obs_wbrd, 3);
    step(1, 3, 1, 0, 0, 1, 10, 1, 0); check("t2_fire_c5", obs_fire, 1);
    idle(2);

    // Writeback-port conflict
    step(1, 0, 0, 0, 0, 1, 2, 4, 0);
    step(1, 0, 0, 0, 0, 1, 7, 3, 0); check("t3_wbc_stall_c1", obs_stall, 1);
    step(1, 0, 0, 0, 0, 1, 7, 3, 0); check("t3_fire_c2", obs_fire, 1);
    idle(1);
    idle(1);  check("t3_wb_c4", obs_wb, 1); check("t3_wbrd_c4", obs_wbrd, 2);
    idle(1);  check("t3_wb_c5", obs_wb, 1); check("t3_wbrd_c5", obs_wbrd, 7);
    idle(1);

    // WAW on rd=9
    step(1, 0, 0, 0, 0, 1, 9, 6, 0);
    for (int c = 1; c <= 6; c++) begin
      step(1, 0, 0, 0, 0, 1, 9, 1, 0);
      check("t4_waw_stall", obs_stall, 1);
    end
    step(1, 0, 0, 0, 0, 1, 9, 1, 0); check("t4_fire_c7", obs_fire, 1);
    check("t4_busy9_c7", obs_busy[9], 0);
    idle(2);

    // Flush kills L=3 issue
    step(1, 0, 0, 0, 0, 1, 4, 3, 0);
    step(1, 0, 0, 0, 0, 1, 6, 2, 1); check("t5_nofire_c1", obs_fire, 0);
    idle(1);  check("t5_busy4_c2", obs_busy[4], 0);
    idle(1);  check("t5_nowb_c3", obs_wb, 0);
    idle(1);

    // Flush kills L=1 issue
    step(1, 0, 0, 0, 0, 1, 4, 1, 0);
    step(1, 0, 0, 0, 0, 1, 6, 1, 1); check("t6_nowb_c1", obs_wb, 0);
    idle(2);

    // Asynchronous reset with three ops in flight
    step(1, 0, 0, 0, 0, 1, 11, 8, 0);
    step(1, 0, 0, 0, 0, 1, 12, 8, 0);
    step(1, 0, 0, 0, 0, 1, 13, 8, 0);
    check("t7_infl_before", ifc.inflight_o, 3);
    drive(1, 0, 0, 0, 0, 1, 14, 2, 0);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    pend.delete();
    lv = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 4) != 0,
           $urandom_range(0, 7), $urandom_range(1, LAT_MAX), $urandom_range(0, 11) == 0);
    end
    idle(LAT_MAX + 1);
    check("final_inflight", ifc.inflight_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
